task_xd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one clock-domain-crossing task channel among `C_NUM_REQ` requesters in the issuing clock domain. It sits directly on the issuing-side start/busy/done ports of the task-acknowledge crossing. It grants one requester at a time, holds that requester's payload stable until the far domain reports completion, and returns per-requester done and timeout pulses.

---
 rtl/task_xd_arbiter.sv | 143 ++++++++++++++
 tb/tb_task_xd_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/task_xd_arbiter.sv
// Round-robin arbiter/sequencer sharing one clock-domain-crossing task channel among C_NUM_REQ requesters.
// Optional WAIT watchdog (req_err / timeout_sticky) is built only when TASK_XD_ARB_TIMEOUT_EN is defined.
module task_xd_arbiter #(
  parameter int unsigned C_NUM_REQ       = 4,
  parameter int unsigned C_DATA_WIDTH    = 32,
  parameter int unsigned C_ID_WIDTH      = 2,
  parameter int unsigned C_TIMEOUT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_NUM_REQ-1:0]              req_valid,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_data,
  output logic [C_NUM_REQ-1:0]              req_ready,
  output logic [C_NUM_REQ-1:0]              req_done,
  output logic [C_NUM_REQ-1:0]              req_err,
  output logic                              task_start,
  output logic [C_DATA_WIDTH-1:0]           task_data,
  input  logic                              task_busy,
  input  logic                              task_done,
  output logic [C_ID_WIDTH-1:0]             cur_id,
  output logic                              arb_busy,
  input  logic                              err_clr,
  output logic                              timeout_sticky
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } arbStateT;

  arbStateT                  state;
  arbStateT                  nextState;
  logic [C_ID_WIDTH-1:0]     last;
  logic [C_ID_WIDTH-1:0]     winner;
  logic [C_ID_WIDTH-1:0]     cand;
  logic [C_DATA_WIDTH-1:0]   winData;
  logic                      anyValid;
  logic                      grant;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin : rrSearch
    winner   = last;
    anyValid = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= C_NUM_REQ; i++) begin
      cand = C_ID_WIDTH'((32'(last) + i) % C_NUM_REQ);
      if (!anyValid && req_valid[cand]) begin
        anyValid = 1'b1;
        winner   = cand;
      end
    end
  end

  always_comb begin : dataMux
    winData = '0;
    for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
      if (winner == C_ID_WIDTH'(i)) winData = req_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin : fsmReg
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // A busy channel in IDLE is a task left over from before reset: grant nothing until it drains.
  always_comb begin : fsmNext
    nextState  = state;
    grant      = 1'b0;
    req_ready  = '0;
    task_start = 1'b0;
    arb_busy   = 1'b1;
    case (state)
      IDLE: begin
        arb_busy = 1'b0;
        if (!task_busy && anyValid) begin
          grant     = 1'b1;
          req_ready = C_NUM_REQ'(1) << winner;
          nextState = START;
        end
      end
      START: begin
        task_start = 1'b1;
        nextState  = WAIT;
      end
      WAIT: begin
        if (task_done) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : dataPath
    if (rst) begin
      last      <= C_ID_WIDTH'(C_NUM_REQ - 1);
      cur_id    <= '0;
      task_data <= '0;
      req_done  <= '0;
    end else begin
      req_done <= '0;
      if (grant) begin
        task_data <= winData;
        cur_id    <= winner;
        last      <= winner;
      end
      if (state == WAIT && task_done) req_done <= C_NUM_REQ'(1) << cur_id;
    end
  end

`ifdef TASK_XD_ARB_TIMEOUT_EN
  logic [C_TIMEOUT_WIDTH-1:0] wdCount;
  logic                       wdExpire;

  // Fires on the edge that takes the counter to all-ones, i.e. only once per task.
  assign wdExpire = (state == WAIT) && (wdCount == {{(C_TIMEOUT_WIDTH-1){1'b1}}, 1'b0});

  always_ff @(posedge clk or posedge rst) begin : watchdog
    if (rst) begin
      wdCount        <= '0;
      req_err        <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      req_err <= '0;
      if (state == START) wdCount <= '0;
      else if (state == WAIT && wdCount != '1) wdCount <= wdCount + C_TIMEOUT_WIDTH'(1);
      if (wdExpire) begin
        req_err        <= C_NUM_REQ'(1) << cur_id;
        timeout_sticky <= 1'b1;
      end else if (err_clr) begin
        timeout_sticky <= 1'b0;
      end
    end
  end
`else
  logic unusedCfg;

  assign unusedCfg      = err_clr | (C_TIMEOUT_WIDTH == 0);
  assign req_err        = '0;
  assign timeout_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_task_xd_arbiter.sv
// Directed self-checking bench for task_xd_arbiter (4 requesters, 32-bit payload, 4-bit watchdog).
// Timeout expectations follow TASK_XD_ARB_TIMEOUT_EN when it is defined for the build.
module tb_task_xd_arbiter;

`ifdef TASK_XD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   req_done;
  logic [3:0]   req_err;
  logic         task_start;
  logic [31:0]  task_data;
  logic         task_busy;
  logic         task_done;
  logic [1:0]   cur_id;
  logic         arb_busy;
  logic         err_clr;
  logic         timeout_sticky;

  int unsigned  nCmp;
  int unsigned  nFail;
  logic         expSticky;

  task_xd_arbiter #(
    .C_NUM_REQ      (4),
    .C_DATA_WIDTH   (32),
    .C_ID_WIDTH     (2),
    .C_TIMEOUT_WIDTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .req_done      (req_done),
    .req_err       (req_err),
    .task_start    (task_start),
    .task_data     (task_data),
    .task_busy     (task_busy),
    .task_done     (task_done),
    .cur_id        (cur_id),
    .arb_busy      (arb_busy),
    .err_clr       (err_clr),
    .timeout_sticky(timeout_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkWait(input int w, input logic [3:0] oneHot, input logic [31:0] expData);
    if (TO_EN && w == 15) expSticky = 1'b1;
    chk("wait_start",  task_start, 0);
    chk("wait_data",   task_data, expData);
    chk("wait_done",   req_done, 0);
    chk("wait_ready",  req_ready, 0);
    chk("wait_busy",   arb_busy, 1);
    chk("wait_err",    req_err, (TO_EN && w == 15) ? oneHot : 4'b0000);
    chk("wait_sticky", timeout_sticky, expSticky);
  endtask

  // Entered in the grant cycle with inputs settled; returns in the cycle after task_done.
  task automatic doTask(input int id, input int lat, input logic [3:0] vWait, input logic [3:0] vEnd);
    logic [3:0]  oneHot;
    logic [31:0] expData;
    oneHot  = 4'b0001 << id;
    expData = req_data[id*32 +: 32];
    chk("grant", req_ready, oneHot);
    tick();
    req_valid = vWait;
    task_busy = 1'b1;
    task_done = 1'b0;
    #1;
    chk("start",      task_start, 1);
    chk("start_data", task_data, expData);
    chk("start_id",   cur_id, id);
    chk("start_busy", arb_busy, 1);
    chk("start_rdy",  req_ready, 0);
    for (int i = 2; i <= lat; i++) begin
      tick();
      chkWait(i - 2, oneHot, expData);
    end
    tick();
    req_valid = vEnd;
    task_done = 1'b1;
    task_busy = 1'b0;
    #1;
    chkWait(lat - 1, oneHot, expData);
    tick();
    task_done = 1'b0;
    #1;
    chk("done",      req_done, oneHot);
    chk("done_idle", arb_busy, 0);
    chk("done_err",  req_err, 0);
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = '0;
    task_busy = 1'b0;
    task_done = 1'b0;
    err_clr   = 1'b0;
    expSticky = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    nCmp      = 0;
    nFail     = 0;
    expSticky = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    task_busy = 1'b0;
    task_done = 1'b0;
    err_clr   = 1'b0;
    #3;
    chk("rst_ready",  req_ready, 0);
    chk("rst_done",   req_done, 0);
    chk("rst_err",    req_err, 0);
    chk("rst_start",  task_start, 0);
    chk("rst_data",   task_data, 0);
    chk("rst_id",     cur_id, 0);
    chk("rst_busy",   arb_busy, 0);
    chk("rst_sticky", timeout_sticky, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Single request, done 7 cycles after start.
    req_data[31:0] = 32'hDEADBEEF;
    req_valid      = 4'b0001;
    #1;
    doTask(0, 7, 4'b0000, 4'b0000);
    tick();
    chk("done_once", req_done, 0);
    chk("idle_rdy",  req_ready, 0);

    // All four continuously valid: order 0,1,2,3,0.
    doReset();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = {8'(i + 1), 24'hC0FFEE};
    req_valid = 4'b1111;
    #1;
    doTask(0, 3, 4'b1111, 4'b1111);
    doTask(1, 3, 4'b1111, 4'b1111);
    doTask(2, 3, 4'b1111, 4'b1111);
    doTask(3, 3, 4'b1111, 4'b1111);
    doTask(0, 3, 4'b1111, 4'b1111);
    chk("rr_next", req_ready, 4'b0010);
    req_valid = '0;

    // Reset during WAIT while the crossing stays busy for 20 cycles.
    doReset();
    req_data[31:0] = 32'hA5A5_5A5A;
    req_valid      = 4'b0001;
    #1;
    chk("pre_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    task_busy = 1'b1;
    tick();
    tick();
    chk("pre_wait", arb_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy",  arb_busy, 0);
    chk("arst_data",  task_data, 0);
    chk("arst_start", task_start, 0);
    req_valid = 4'b1111;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("blk_ready", req_ready, 0);
      chk("blk_start", task_start, 0);
      chk("blk_done",  req_done, 0);
      chk("blk_busy",  arb_busy, 0);
      tick();
    end
    req_valid = 4'b0000;
    task_busy = 1'b0;
    task_done = 1'b1;
    #1;
    chk("stray_rdy", req_ready, 0);
    tick();
    task_done = 1'b0;
    #1;
    chk("stray_done", req_done, 0);
    chk("stray_idle", arb_busy, 0);
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h5000_0000 + 32'(i);
    req_valid = 4'b1111;
    #1;
    doTask(0, 4, 4'b1111, 4'b1111);
    chk("resume_next", req_ready, 4'b0010);
    req_valid = '0;

    // Withdrawal: requester 2 raises valid during requester 1's grant, drops it before IDLE.
    doReset();
    req_data[63:32] = 32'h1111_1111;
    req_data[95:64] = 32'h2222_2222;
    req_valid       = 4'b0110;
    #1;
    doTask(1, 5, 4'b0100, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      chk("wd_ready", req_ready, 0);
      chk("wd_idle",  arb_busy, 0);
      tick();
    end

    // Watchdog: done 30 cycles after start.
    doReset();
    req_data[31:0] = 32'h0BAD_F00D;
    req_valid      = 4'b0001;
    #1;
    doTask(0, 30, 4'b0000, 4'b0000);
    chk("to_sticky", timeout_sticky, expSticky);
    err_clr = 1'b1;
    tick();
    err_clr   = 1'b0;
    expSticky = 1'b0;
    #1;
    chk("to_clr",  timeout_sticky, 0);
    chk("to_err0", req_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
